// File: rtl/entrada_operandos.sv
// Keypad operand entry controller feeding the 4-digit BCD adder.
// Optional backspace key (0xD) enabled by defining ENTRADA_BORRADO_EN.
//
// state    | meaning
// ENTRY_A  | entering first operand
// ENTRY_B  | entering second operand, first held in numero_sv
// WAIT_RES | add requested, waiting for adder result-ready (ent)
// SHOW     | result shown; a digit starts a fresh calculation
module entrada_operandos (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic            ent,
  output logic [3:0][3:0] numero,
  output logic [3:0][3:0] numero_sv,
  output logic            suma,
  output logic            finalizar,
  output logic [2:0]      digit_cnt,
  output logic [1:0]      estado
);

  typedef enum logic [1:0] {
    ENTRY_A  = 2'd0,
    ENTRY_B  = 2'd1,
    WAIT_RES = 2'd2,
    SHOW     = 2'd3
  } state_t;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_EQUAL = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  state_t          state_q, state_n;
  logic [3:0][3:0] numero_n, numero_sv_n;
  logic [2:0]      cnt_n;
  logic            suma_n, fin_n;

  logic is_digit, is_plus, is_equal, is_clear, can_shift, has_digits;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_plus    = key_valid && (key_code == KEY_PLUS);
  assign is_equal   = key_valid && (key_code == KEY_EQUAL);
  assign is_clear   = key_valid && (key_code == KEY_CLEAR);
  assign can_shift  = is_digit && (digit_cnt < 3'd4);
  assign has_digits = (digit_cnt != 3'd0);

`ifdef ENTRADA_BORRADO_EN
  localparam logic [3:0] KEY_BACK = 4'hD;
  logic is_back;
  assign is_back = key_valid && (key_code == KEY_BACK);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ENTRY_A;
      numero    <= '0;
      numero_sv <= '0;
      digit_cnt <= '0;
      suma      <= 1'b0;
      finalizar <= 1'b0;
    end else begin
      state_q   <= state_n;
      numero    <= numero_n;
      numero_sv <= numero_sv_n;
      digit_cnt <= cnt_n;
      suma      <= suma_n;
      finalizar <= fin_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    numero_n    = numero;
    numero_sv_n = numero_sv;
    cnt_n       = digit_cnt;
    suma_n      = 1'b0;
    fin_n       = 1'b0;

    // Clear wins over everything, including a same-cycle ent in WAIT_RES.
    if (is_clear) begin
      fin_n       = 1'b1;
      numero_n    = '0;
      numero_sv_n = '0;
      cnt_n       = '0;
      state_n     = ENTRY_A;
    end else begin
      unique case (state_q)
        ENTRY_A, ENTRY_B: begin
          if (can_shift) begin
            numero_n = {numero[2:0], key_code};
            cnt_n    = digit_cnt + 3'd1;
          end else if (is_plus && has_digits && (state_q == ENTRY_A)) begin
            numero_sv_n = numero;
            numero_n    = '0;
            cnt_n       = '0;
            state_n     = ENTRY_B;
          end else if (is_equal && has_digits && (state_q == ENTRY_B)) begin
            suma_n  = 1'b1;
            state_n = WAIT_RES;
          end
`ifdef ENTRADA_BORRADO_EN
          else if (is_back && has_digits) begin
            numero_n = {4'h0, numero[3:1]};
            cnt_n    = digit_cnt - 3'd1;
          end
`endif
        end
        WAIT_RES: begin
          if (ent) state_n = SHOW;
        end
        SHOW: begin
          if (is_digit) begin
            fin_n       = 1'b1;
            numero_sv_n = '0;
            numero_n    = {12'h000, key_code};
            cnt_n       = 3'd1;
            state_n     = ENTRY_A;
          end
        end
        default: state_n = ENTRY_A;
      endcase
    end
  end

  assign estado = state_q;

endmodule

// File: tb/tb_entrada_operandos.sv
// Directed vector bench for entrada_operandos; backspace expectations follow ENTRADA_BORRADO_EN.
module tb_entrada_operandos;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            key_valid = 1'b0;
  logic [3:0]      key_code = 4'h0;
  logic            ent = 1'b0;
  logic [3:0][3:0] numero, numero_sv;
  logic            suma, finalizar;
  logic [2:0]      digit_cnt;
  logic [1:0]      estado;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  entrada_operandos dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .ent(ent),
    .numero(numero), .numero_sv(numero_sv), .suma(suma), .finalizar(finalizar),
    .digit_cnt(digit_cnt), .estado(estado)
  );

  typedef struct {
    logic        r;
    logic        kv;
    logic [3:0]  kc;
    logic        e;
    logic [15:0] x_num;
    logic [15:0] x_sv;
    logic        x_suma;
    logic        x_fin;
    logic [2:0]  x_cnt;
    logic [1:0]  x_est;
  } vec_t;

  vec_t v[35];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic kv, input logic [3:0] kc, input logic e);
    rst = r; key_valid = kv; key_code = kc; ent = e;
    @(posedge clk);
    #1;
    rst = 1'b0; key_valid = 1'b0; key_code = 4'h0; ent = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] xn, input logic [15:0] xs,
                         input logic xsu, input logic xf, input logic [2:0] xc, input logic [1:0] xe);
    chk({tag, ".numero"},    32'(numero),    32'(xn));
    chk({tag, ".numero_sv"}, 32'(numero_sv), 32'(xs));
    chk({tag, ".suma"},      32'(suma),      32'(xsu));
    chk({tag, ".finalizar"}, 32'(finalizar), 32'(xf));
    chk({tag, ".digit_cnt"}, 32'(digit_cnt), 32'(xc));
    chk({tag, ".estado"},    32'(estado),    32'(xe));
  endtask

  initial begin
    //      rst kv code ent  numero    sv       suma fin cnt est
    v[0]  = '{1, 1, 4'h5, 0, 16'h0000, 16'h0000, 0, 0, 0, 0}; // reset beats key
    v[1]  = '{0, 1, 4'h1, 0, 16'h0001, 16'h0000, 0, 0, 1, 0};
    v[2]  = '{0, 1, 4'h2, 0, 16'h0012, 16'h0000, 0, 0, 2, 0};
    v[3]  = '{0, 1, 4'h3, 0, 16'h0123, 16'h0000, 0, 0, 3, 0};
    v[4]  = '{0, 1, 4'hA, 0, 16'h0000, 16'h0123, 0, 0, 0, 1};
    v[5]  = '{0, 1, 4'hA, 0, 16'h0000, 16'h0123, 0, 0, 0, 1}; // '+' in B
    v[6]  = '{0, 1, 4'hB, 0, 16'h0000, 16'h0123, 0, 0, 0, 1}; // '=' empty
    v[7]  = '{0, 1, 4'h4, 0, 16'h0004, 16'h0123, 0, 0, 1, 1};
    v[8]  = '{0, 1, 4'h5, 0, 16'h0045, 16'h0123, 0, 0, 2, 1};
    v[9]  = '{0, 1, 4'hA, 0, 16'h0045, 16'h0123, 0, 0, 2, 1};
    v[10] = '{0, 1, 4'hE, 0, 16'h0045, 16'h0123, 0, 0, 2, 1};
    v[11] = '{0, 1, 4'hB, 0, 16'h0045, 16'h0123, 1, 0, 2, 2}; // add request
    v[12] = '{0, 0, 4'h0, 0, 16'h0045, 16'h0123, 0, 0, 2, 2};
    v[13] = '{0, 1, 4'h7, 0, 16'h0045, 16'h0123, 0, 0, 2, 2};
    v[14] = '{0, 1, 4'hB, 0, 16'h0045, 16'h0123, 0, 0, 2, 2};
    v[15] = '{0, 0, 4'h0, 1, 16'h0045, 16'h0123, 0, 0, 2, 3}; // ent -> SHOW
    v[16] = '{0, 0, 4'h0, 1, 16'h0045, 16'h0123, 0, 0, 2, 3};
    v[17] = '{0, 1, 4'hA, 0, 16'h0045, 16'h0123, 0, 0, 2, 3};
    v[18] = '{0, 1, 4'h3, 0, 16'h0003, 16'h0000, 0, 1, 1, 0}; // new digit after result
    v[19] = '{0, 0, 4'h0, 0, 16'h0003, 16'h0000, 0, 0, 1, 0};
    v[20] = '{0, 1, 4'hB, 0, 16'h0003, 16'h0000, 0, 0, 1, 0};
    v[21] = '{0, 1, 4'hF, 0, 16'h0003, 16'h0000, 0, 0, 1, 0};
    v[22] = '{0, 1, 4'hC, 0, 16'h0000, 16'h0000, 0, 1, 0, 0};
    v[23] = '{0, 1, 4'hA, 0, 16'h0000, 16'h0000, 0, 0, 0, 0}; // '+' empty
    v[24] = '{0, 1, 4'h9, 0, 16'h0009, 16'h0000, 0, 0, 1, 0};
    v[25] = '{0, 1, 4'h8, 0, 16'h0098, 16'h0000, 0, 0, 2, 0};
    v[26] = '{0, 1, 4'h7, 0, 16'h0987, 16'h0000, 0, 0, 3, 0};
    v[27] = '{0, 1, 4'h6, 0, 16'h9876, 16'h0000, 0, 0, 4, 0};
    v[28] = '{0, 1, 4'h5, 0, 16'h9876, 16'h0000, 0, 0, 4, 0}; // saturated
    v[29] = '{0, 0, 4'h0, 1, 16'h9876, 16'h0000, 0, 0, 4, 0}; // stray ent
    v[30] = '{0, 1, 4'hA, 0, 16'h0000, 16'h9876, 0, 0, 0, 1};
    v[31] = '{0, 1, 4'h1, 0, 16'h0001, 16'h9876, 0, 0, 1, 1};
    v[32] = '{0, 1, 4'hB, 0, 16'h0001, 16'h9876, 1, 0, 1, 2};
    v[33] = '{0, 1, 4'hC, 1, 16'h0000, 16'h0000, 0, 1, 0, 0}; // clear beats ent
    v[34] = '{0, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0};

    for (int i = 0; i < 35; i++) begin
      step(v[i].r, v[i].kv, v[i].kc, v[i].e);
      chk_all($sformatf("vec%0d", i), v[i].x_num, v[i].x_sv, v[i].x_suma,
              v[i].x_fin, v[i].x_cnt, v[i].x_est);
    end

    // Backspace sequence, result depends on build configuration.
    step(0, 1, 4'h1, 0);
    step(0, 1, 4'h2, 0);
    step(0, 1, 4'h3, 0);
    step(0, 1, 4'hD, 0);
`ifdef ENTRADA_BORRADO_EN
    chk_all("bksp", 16'h0012, 16'h0000, 0, 0, 3'd2, 2'd0);
    step(0, 1, 4'hD, 0);
    step(0, 1, 4'hD, 0);
    step(0, 1, 4'hD, 0);
    chk_all("bksp_empty", 16'h0000, 16'h0000, 0, 0, 3'd0, 2'd0);
`else
    chk_all("bksp_off", 16'h0123, 16'h0000, 0, 0, 3'd3, 2'd0);
`endif

    // Reset mid-entry with a same-cycle clear key: no finalizar.
    step(0, 1, 4'h7, 0);
    step(1, 1, 4'hC, 0);
    chk_all("rst_clear", 16'h0000, 16'h0000, 0, 0, 3'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/entrada_operandos.md
# entrada_operandos

Keypad-side operand entry controller for the 4-digit BCD calculator datapath: it writes the two operands and the control strobes that the BCD adder reads. Decimal digit keys are shifted into a 4-digit BCD entry register; a '+' key latches the first operand, an '=' key issues a one-cycle add request, and the block then waits for the adder's result-ready flag. A clear key, or a new digit after a result, issues a one-cycle clear request to the adder.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code valid this cycle
- key_code  in  4  0x0–0x9 digit, 0xA '+', 0xB '=', 0xC clear, 0xD backspace (config-dependent); 0xE–0xF ignored
- ent  in  1  adder result-ready flag; level or pulse
- numero  out  [3:0][3:0]  current entry, BCD, index 0 = least-significant digit
- numero_sv  out  [3:0][3:0]  stored first operand, BCD, index 0 = LSD
- suma  out  1  one-cycle add request
- finalizar  out  1  one-cycle clear request to adder
- digit_cnt  out  3  digits in current entry, 0–4
- estado  out  2  FSM state: 0 ENTRY_A, 1 ENTRY_B, 2 WAIT_RES, 3 SHOW

## Operation
- Reset: numero=0, numero_sv=0, digit_cnt=0, suma=0, finalizar=0, estado=ENTRY_A.
- Digit accept (ENTRY_A/ENTRY_B, digit_cnt<4): numero[3:1] ← numero[2:0], numero[0] ← key, digit_cnt+1. At digit_cnt=4, digits are ignored; there is no wrap and no truncation.
- Leading zeros count as digits.
- ENTRY_A:
  - '+' with digit_cnt≥1: numero_sv ← numero, numero ← 0, digit_cnt ← 0, go to ENTRY_B.
  - '+' with digit_cnt=0: ignored.
  - '=': ignored.
- ENTRY_B:
  - '=' with digit_cnt≥1: suma=1 for one cycle, go to WAIT_RES.
  - '=' with digit_cnt=0: ignored.
  - '+': ignored.
- WAIT_RES:
  - Digit, '+', '=' and backspace are ignored.
  - ent=1 → SHOW.
  - numero and numero_sv are held constant.
- SHOW:
  - Operands held.
  - Digit key: finalizar=1, numero_sv ← 0, numero ← {0,0,0,key}, digit_cnt ← 1, go to ENTRY_A.
  - '+', '=': ignored.
- Clear (0xC), any state: finalizar=1, numero=0, numero_sv=0, digit_cnt=0, go to ENTRY_A.
- ent outside WAIT_RES: ignored.
- Simultaneous key_valid and ent in WAIT_RES: the key is ignored and the state still moves to SHOW, except clear, which wins: go to ENTRY_A with a finalizar pulse.
- Invalid codes 0xE/0xF (and 0xD when the backspace feature is disabled): no effect in any state.

## Timing
- Key sampled at edge k when key_valid=1; register, state and strobe updates are visible after edge k (cycle k+1).
- suma and finalizar are registered. Each is high for exactly one cycle and returns to 0 the next cycle unconditionally. They are never high in the same cycle.
- suma asserts in the same cycle estado first reads WAIT_RES. numero/numero_sv are stable from that cycle until leaving SHOW.
- ent sampled at edge j in WAIT_RES → estado=SHOW at cycle j+1.
- Back-to-back keys on consecutive cycles must all be processed.
- rst overrides every input, including a same-cycle key; no finalizar is issued on reset.

## Configuration
- ENTRADA_BORRADO_EN defined: key 0xD acts as backspace in ENTRY_A/ENTRY_B when digit_cnt≥1.
  - Effect: numero[2:0] ← numero[3:1], numero[3] ← 0, digit_cnt−1.
  - Ignored at digit_cnt=0 and in WAIT_RES/SHOW.
- Not defined: 0xD is ignored everywhere, and no backspace logic is synthesized.

## Test plan
- Entry and add request:
  - Stimulus: rst, then keys 1,2,3,'+',4,5,'='.
  - Expected: numero_sv={0,1,2,3} (d3..d0); numero={0,0,4,5}; suma high exactly one cycle after the '=' edge; estado=WAIT_RES.
- Digit saturation:
  - Stimulus: keys 9,8,7,6,5.
  - Expected: numero={9,8,7,6}, digit_cnt=4; the fifth digit has no effect.
- Result handoff:
  - Stimulus: in WAIT_RES, keys 7 and '=' are ignored; then ent=1.
  - Expected: estado=SHOW next cycle.
  - Stimulus: then digit 3.
  - Expected: finalizar one-cycle pulse, numero={0,0,0,3}, numero_sv=0, estado=ENTRY_A.
- Ignored keys:
  - Stimulus: '+' at digit_cnt=0; '=' in ENTRY_A; '+' in ENTRY_B; codes 0xE/0xF.
  - Expected: no register change and no strobe.
- Clear and reset priority:
  - Stimulus: clear in WAIT_RES with ent=1 in the same cycle.
  - Expected: finalizar pulse, ENTRY_A, all operands zero, no SHOW.
  - Stimulus: rst during a key.
  - Expected: reset values, finalizar=0.
- Backspace (ENTRADA_BORRADO_EN defined):
  - Stimulus: keys 1,2,3,0xD.
  - Expected: numero={0,0,0,1}... no — numero={0,0,1,2}, digit_cnt=2.
  - Without the macro, the same stimulus gives numero={0,1,2,3}.
